// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the memory-side blocks of the CPU.
//   word_t      : 32-bit machine word
//   ramstate_t  : status reported by the RAM each cycle (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : mem_arbiter ownership states (IDLE, DSERV, ISERV)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Serialises instruction-fetch and data requests from the caches onto a
// single RAM port. Data requests win; one idle bubble follows every access.
//
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   iREN, iaddr               instruction read request / address
//   iwait, iload              low on the instruction completion cycle / fetched word
//   dREN, dWEN, daddr, dstore data read/write request, address, write value
//   dwait, dload              low on the data completion cycle / read value
//   ramREN, ramWEN            RAM read/write strobes
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramstate         RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   memerr                    one-cycle pulse when an access ends in ERROR
//
// Configuration:
//   MEM_ARBITER_STARVE_GUARD_EN  when defined, after STARVE_LIMIT consecutive
//                                data grants with a fetch pending, the fetch is
//                                granted ahead of any pending data request.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    arb_state_t state;
    ramstate_t  rs;
    logic       dreq;
    logic       done;
    logic       starved;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;
    assign done = (rs == ACCESS) || (rs == ERROR);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starveCnt;

    assign starved = iREN && (starveCnt == CW'(STARVE_LIMIT));

    // Counts data grants made while a fetch waits. Any idle cycle that does
    // not hand the port to data-over-fetch (no fetch pending, or a fetch
    // grant) restarts the count.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            starveCnt <= '0;
        end else if (state == IDLE) begin
            if (!iREN || starved || !dreq)
                starveCnt <= '0;
            else
                starveCnt <= starveCnt + 1'b1;
        end
    end
`else
    // Strict data priority. The comparison is never true for a legal limit;
    // it only keeps the parameter referenced in this build.
    assign starved = (STARVE_LIMIT < 0);
`endif

    // Ownership FSM. A dropped request or a terminal RAM status (ACCESS or
    // ERROR) returns the port to IDLE, which gives the mandatory bubble.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (starved)
                        state <= ISERV;
                    else if (dreq)
                        state <= DSERV;
                    else if (iREN)
                        state <= ISERV;
                end
                DSERV: if (!dreq || done) state <= IDLE;
                ISERV: if (!iREN || done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output mux: purely a function of ownership and the live inputs, so
    // completion and request drops are visible in the same cycle.
    always_comb begin
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        memerr   = 1'b0;
        case (state)
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (dreq) begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (rs == ACCESS) begin
                        dwait = 1'b0;
                        dload = dWEN ? '0 : ramload;
                    end else if (rs == ERROR) begin
                        dwait  = 1'b0;
                        memerr = 1'b1;
                    end
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                if (iREN) begin
                    ramREN = 1'b1;
                    if (rs == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end else if (rs == ERROR) begin
                        iwait  = 1'b0;
                        memerr = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: an ownership-level reference model
// checked every cycle, plus hand-computed expectations for the listed
// scenarios. Build with MEM_ARBITER_STARVE_GUARD_EN defined or not.
module tb_mem_arbiter;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;

    localparam int LIMIT = 4;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    // Model: who owns the RAM port (0 none, 1 data, 2 instruction) and how
    // many data grants in a row were made while a fetch was waiting.
    int mOwner = 0;
    int mRun   = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic dr, input logic dw,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] ds, input logic [31:0] rl,
                                 input logic [1:0] rst);
        iREN = ir; dREN = dr; dWEN = dw;
        iaddr = ia; daddr = da; dstore = ds;
        ramload = rl; ramstate = rst;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Model ownership update, from the arbitration rules.
    always @(posedge CLK) begin
        bit fin;
        fin = (ramstate == 2'd2) || (ramstate == 2'd3);
        if (!nRST) begin
            mOwner = 0;
            mRun   = 0;
        end else if (mOwner == 0) begin
`ifdef MEM_ARBITER_STARVE_GUARD_EN
            if (iREN && mRun == LIMIT) begin
                mOwner = 2; mRun = 0;
            end else
`endif
            if (dREN || dWEN) begin
                mOwner = 1; mRun = iREN ? mRun + 1 : 0;
            end else begin
                if (iREN) mOwner = 2;
                mRun = 0;
            end
        end else if (mOwner == 1) begin
            if (!(dREN || dWEN) || fin) mOwner = 0;
        end else begin
            if (!iREN || fin) mOwner = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        logic        eIw, eDw, eRr, eRw, eErr;
        logic [31:0] eIl, eDl, eAd, eSt;
        if (checkEn) begin
            eIw = 1; eDw = 1; eRr = 0; eRw = 0; eErr = 0;
            eIl = 0; eDl = 0; eAd = 0; eSt = 0;
            if (mOwner == 1) begin
                eAd = daddr; eSt = dstore;
                if (dREN || dWEN) begin
                    if (dWEN) eRw = 1; else eRr = 1;
                    if (ramstate == 2'd2) begin
                        eDw = 0; eDl = dWEN ? 32'h0 : ramload;
                    end else if (ramstate == 2'd3) begin
                        eDw = 0; eErr = 1;
                    end
                end
            end else if (mOwner == 2) begin
                eAd = iaddr;
                if (iREN) begin
                    eRr = 1;
                    if (ramstate == 2'd2) begin
                        eIw = 0; eIl = ramload;
                    end else if (ramstate == 2'd3) begin
                        eIw = 0; eErr = 1;
                    end
                end
            end
            checkOutput("cyc_iwait", {31'd0, iwait}, {31'd0, eIw});
            checkOutput("cyc_iload", iload, eIl);
            checkOutput("cyc_dwait", {31'd0, dwait}, {31'd0, eDw});
            checkOutput("cyc_dload", dload, eDl);
            checkOutput("cyc_ramREN", {31'd0, ramREN}, {31'd0, eRr});
            checkOutput("cyc_ramWEN", {31'd0, ramWEN}, {31'd0, eRw});
            checkOutput("cyc_ramaddr", ramaddr, eAd);
            checkOutput("cyc_ramstore", ramstore, eSt);
            checkOutput("cyc_memerr", {31'd0, memerr}, {31'd0, eErr});
        end
    end

    initial begin
        int firstI;
        int dDone;

        nRST = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd0);
        step();
        checkEn = 1;
        step();
        checkOutput("rst_iwait", {31'd0, iwait}, 32'd1);
        checkOutput("rst_dwait", {31'd0, dwait}, 32'd1);
        checkOutput("rst_ramREN", {31'd0, ramREN}, 32'd0);
        checkOutput("rst_ramaddr", ramaddr, 32'd0);
        checkOutput("rst_memerr", {31'd0, memerr}, 32'd0);
        nRST = 1;

        // Instruction fetch, RAM ready on the first strobed cycle.
        applyStimulus(1, 0, 0, 32'h40, 0, 0, 0, 2'd0);
        checkOutput("if_c0_ramREN", {31'd0, ramREN}, 32'd0);
        step();
        applyStimulus(1, 0, 0, 32'h40, 0, 0, 32'h8C220004, 2'd2);
        checkOutput("if_c1_ramREN", {31'd0, ramREN}, 32'd1);
        checkOutput("if_c1_ramaddr", ramaddr, 32'h40);
        checkOutput("if_c1_iwait", {31'd0, iwait}, 32'd0);
        checkOutput("if_c1_iload", iload, 32'h8C220004);
        step();
        applyStimulus(0, 0, 0, 32'h40, 0, 0, 32'h8C220004, 2'd2);
        checkOutput("if_c2_ramREN", {31'd0, ramREN}, 32'd0);
        checkOutput("if_c2_iwait", {31'd0, iwait}, 32'd1);
        step();

        // Data write beats a simultaneous fetch; RAM busy for two cycles.
        applyStimulus(1, 0, 1, 32'h80, 32'h100, 32'hDEADBEEF, 32'h55, 2'd1);
        step();
        checkOutput("wr_c1_ramWEN", {31'd0, ramWEN}, 32'd1);
        checkOutput("wr_c1_ramREN", {31'd0, ramREN}, 32'd0);
        checkOutput("wr_c1_ramaddr", ramaddr, 32'h100);
        checkOutput("wr_c1_ramstore", ramstore, 32'hDEADBEEF);
        checkOutput("wr_c1_dwait", {31'd0, dwait}, 32'd1);
        step();
        checkOutput("wr_c2_dwait", {31'd0, dwait}, 32'd1);
        step();
        applyStimulus(1, 0, 1, 32'h80, 32'h100, 32'hDEADBEEF, 32'h55, 2'd2);
        checkOutput("wr_c3_dwait", {31'd0, dwait}, 32'd0);
        checkOutput("wr_c3_dload", dload, 32'd0);
        checkOutput("wr_c3_iwait", {31'd0, iwait}, 32'd1);
        step();
        applyStimulus(1, 0, 0, 32'h80, 32'h100, 32'hDEADBEEF, 32'h55, 2'd0);
        checkOutput("wr_c4_idle", {30'd0, ramWEN, ramREN}, 32'd0);
        step();
        applyStimulus(1, 0, 0, 32'h80, 32'h100, 32'hDEADBEEF, 32'h1234, 2'd2);
        checkOutput("wr_c5_ramREN", {31'd0, ramREN}, 32'd1);
        checkOutput("wr_c5_ramaddr", ramaddr, 32'h80);
        checkOutput("wr_c5_iload", iload, 32'h1234);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd0);
        step();

        // Data read terminated by ERROR.
        applyStimulus(0, 1, 0, 0, 32'h200, 0, 32'hFFFF0000, 2'd3);
        step();
        checkOutput("err_dwait", {31'd0, dwait}, 32'd0);
        checkOutput("err_dload", dload, 32'd0);
        checkOutput("err_memerr", {31'd0, memerr}, 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 32'h200, 0, 32'hFFFF0000, 2'd3);
        checkOutput("err_after_memerr", {31'd0, memerr}, 32'd0);
        step();

        // Data read dropped while RAM busy.
        applyStimulus(0, 1, 0, 0, 32'h300, 0, 0, 2'd1);
        step();
        checkOutput("drop_c1_ramREN", {31'd0, ramREN}, 32'd1);
        applyStimulus(0, 0, 0, 0, 32'h300, 0, 0, 2'd1);
        checkOutput("drop_c1_strobe", {30'd0, ramWEN, ramREN}, 32'd0);
        checkOutput("drop_c1_dwait", {31'd0, dwait}, 32'd1);
        step();
        applyStimulus(0, 0, 0, 0, 32'h300, 0, 0, 2'd2);
        checkOutput("drop_c2_dwait", {31'd0, dwait}, 32'd1);
        step();

        // Continuous data and fetch requests with an always-ready RAM.
        firstI = -1;
        dDone  = 0;
        applyStimulus(1, 1, 0, 32'h400, 32'h500, 0, 32'hA5A5A5A5, 2'd2);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            if (!iwait && firstI < 0) firstI = c;
            if (!dwait && firstI < 0) dDone++;
        end
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        checkOutput("starve_first_i", firstI, 32'd9);
        checkOutput("starve_d_before", dDone, 32'd4);
`else
        checkOutput("starve_first_i", firstI, 32'hFFFFFFFF);
        checkOutput("starve_d_before", dDone, 32'd6);
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd0);
        step();
        step();

        // Reset during a busy fetch, then restart.
        applyStimulus(1, 0, 0, 32'h600, 0, 0, 32'h77, 2'd1);
        step();
        checkOutput("rf_c1_ramREN", {31'd0, ramREN}, 32'd1);
        nRST = 0;
        step();
        checkOutput("rf_rst_ramREN", {31'd0, ramREN}, 32'd0);
        checkOutput("rf_rst_ramaddr", ramaddr, 32'd0);
        checkOutput("rf_rst_iwait", {31'd0, iwait}, 32'd1);
        nRST = 1;
        step();
        checkOutput("rf_restart_ramREN", {31'd0, ramREN}, 32'd1);
        checkOutput("rf_restart_ramaddr", ramaddr, 32'h600);
        applyStimulus(1, 0, 0, 32'h600, 0, 0, 32'h77, 2'd2);
        checkOutput("rf_restart_iload", iload, 32'h77);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd0);
        step();

        checkEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that sits directly downstream of the `caches` block. It accepts independent instruction-fetch and data requests from the cache side and serialises them onto one RAM port through a three-state FSM. It returns per-requester wait and load signals. Data requests have priority, and an optional starvation guard bounds instruction-fetch delay.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum number of consecutive data grants issued while iREN is pending. Used only when the guard macro is defined.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  low for exactly the completion cycle of an instruction access.
- iload  out  32  instruction data. Valid when iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  low for exactly the completion cycle of a data access.
- dload  out  32  data read value. Valid when dwait is low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  one-cycle pulse when an access terminates with ERROR.

## Operation
- FSM states:
  - IDLE: no grant.
  - DSERV: data side owns the RAM.
  - ISERV: instruction side owns the RAM.
- IDLE transitions:
  - dREN|dWEN → DSERV.
  - else iREN → ISERV.
  - else stay in IDLE.
- DSERV drives ramaddr=daddr and ramstore=dstore.
  - dWEN asserted: ramWEN=1, ramREN=0. dWEN wins when dREN and dWEN are both asserted.
  - dWEN low: ramREN=dREN.
- ISERV drives ramREN=1, ramaddr=iaddr, ramstore=0, ramWEN=0.
- Completion occurs in the cycle the serviced state sees ramstate==ACCESS.
  - The owner's wait goes low combinationally.
  - The owner's load output equals ramload. dload/iload is 0 on writes.
  - The FSM returns to IDLE on the next edge.
- ERROR in a service state:
  - Treated as completion: wait low and load 0.
  - memerr=1 for that cycle.
  - FSM returns to IDLE.
- FREE or BUSY in a service state: hold the state and the strobes; waits stay high.
- Requester drops its request mid-service (dREN=dWEN=0 in DSERV, or iREN=0 in ISERV): return to IDLE with no completion; strobes drop the same cycle.
- The non-owner's wait is always high, and its load output is 0.
- In IDLE, all RAM outputs are 0 and both waits are high.

## Timing
- Reset, while nRST is low at an edge:
  - state=IDLE.
  - iwait=dwait=1, iload=dload=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0, memerr=0.
  - Guard counter=0.
  - Reset mid-access abandons the access; no completion is signalled.
- Request seen in IDLE at cycle 0 → service state at cycle 1 → RAM strobes asserted at cycle 1.
- Minimum latency is 2 cycles (request to wait-low) when the RAM reports ACCESS in its first strobed cycle.
- A one-cycle IDLE bubble always follows a completion. Back-to-back accesses cost ramLatency+2 cycles each.
- All outputs are combinational functions of state and the current inputs. Only the state and the guard counter are registered.

## Configuration
- MEM_ARBITER_STARVE_GUARD_EN defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments on each IDLE→DSERV grant made while iREN=1.
  - When the counter equals STARVE_LIMIT and iREN=1 in IDLE, ISERV is granted even if a data request is pending.
  - The counter clears on any ISERV grant. It also clears on an IDLE cycle with iREN=0.
- MEM_ARBITER_STARVE_GUARD_EN undefined: strict data priority; no counter is instantiated.

## Structure
- cpu_types_pkg holds:
  - word_t (32-bit).
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR).
  - arb_state_t enum (IDLE, DSERV, ISERV).
- Single module. No sub-module: the FSM and the output mux are small enough to stay flat.

## Test plan
- Instruction read, RAM ACCESS on first cycle: iREN=1, iaddr=0x40, ramload=0x8C220004 → ramREN=1 at cycle 1, iwait=0 and iload=0x8C220004 at cycle 1, IDLE at cycle 2.
- Simultaneous iREN and dWEN (daddr=0x100, dstore=0xDEADBEEF), RAM BUSY for 2 cycles → DSERV first with ramWEN=1; dwait low at cycle 3; ISERV at cycle 5.
- dREN with ERROR returned → dwait=0, dload=0, memerr=1 for one cycle, then IDLE.
- dREN dropped while ramstate=BUSY in DSERV → strobes 0 the same cycle, no dwait-low pulse, IDLE next cycle.
- Guard enabled, STARVE_LIMIT=4, dREN and iREN held continuously → the 5th grant is ISERV; undefined macro → iwait never low.
- nRST low during ISERV with BUSY → next cycle all outputs at reset values; releasing nRST with iREN=1 restarts the fetch.
